// File: rtl/uart_tx_arb_if.sv
// Client request/ack bundle plus transmitter launch/ready handshake for uart_tx_arb.
// slave is the arbiter's view; master is the client/transmitter side.
interface uart_tx_arb_if #(
    parameter int unsigned N_CLIENTS = 4
);
    localparam int unsigned IDW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [N_CLIENTS-1:0]   cli_req;
    logic [8*N_CLIENTS-1:0] cli_data;
    logic [N_CLIENTS-1:0]   cli_last;
    logic [N_CLIENTS-1:0]   cli_ack;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic                   lock_to;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   tx_rdy;

    modport slave (
        input  cli_req, cli_data, cli_last, tx_rdy,
        output cli_ack, grant_id, busy, lock_to, tx_start, tx_data
    );

    modport master (
        output cli_req, cli_data, cli_last, tx_rdy,
        input  cli_ack, grant_id, busy, lock_to, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter among N_CLIENTS.
// A granted client keeps the transmitter until its last byte or a request-gap timeout.
module uart_tx_arb #(
    parameter int unsigned N_CLIENTS   = 4,
    parameter int unsigned GAP_TIMEOUT = 26050
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_arb_if.slave bus
);
    localparam int unsigned IDW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic [2:0] {
        StArb,
        StStart,
        StWaitLo,
        StWaitHi,
        StNext
    } state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic [N_CLIENTS-1:0] ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 lock_to_q, lock_to_d;
    logic                 last_q, last_d;
    logic [15:0]          gap_cnt_q, gap_cnt_d;

    logic                 win_vld;
    logic [IDW-1:0]       win_id;

    // (base + off) mod N_CLIENTS, with off < N_CLIENTS
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_CLIENTS) begin
            s = s - N_CLIENTS;
        end
        return IDW'(s);
    endfunction

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            if (!win_vld && bus.cli_req[wrap_add(rr_ptr_q, k)]) begin
                win_vld = 1'b1;
                win_id  = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        busy_d     = busy_q;
        gap_cnt_d  = gap_cnt_q;
        tx_start_d = 1'b0;
        ack_d      = '0;
        lock_to_d  = 1'b0;

        unique case (state_q)
            StArb: begin
                if (bus.tx_rdy && win_vld) begin
                    grant_d        = win_id;
                    tx_data_d      = bus.cli_data[{win_id, 3'b000} +: 8];
                    last_d         = bus.cli_last[win_id];
                    busy_d         = 1'b1;
                    tx_start_d     = 1'b1;
                    ack_d[win_id]  = 1'b1;
                    state_d        = StStart;
                end else begin
                    busy_d = 1'b0;
                end
            end

            StStart: begin
                state_d = StWaitLo;
            end

            // Ignore a stale-high tx_rdy until the frame has visibly started.
            StWaitLo: begin
                if (!bus.tx_rdy) begin
                    state_d = StWaitHi;
                end
            end

            StWaitHi: begin
                if (bus.tx_rdy) begin
                    if (last_q) begin
                        rr_ptr_d = wrap_add(grant_q, 1);
                        busy_d   = 1'b0;
                        state_d  = StArb;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = StNext;
                    end
                end
            end

            // Locked to grant_q; a request on the timeout cycle still wins.
            StNext: begin
                if (bus.cli_req[grant_q]) begin
                    tx_data_d      = bus.cli_data[{grant_q, 3'b000} +: 8];
                    last_d         = bus.cli_last[grant_q];
                    tx_start_d     = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = StStart;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                    if (gap_cnt_q == 16'(GAP_TIMEOUT - 1)) begin
                        lock_to_d = 1'b1;
                        busy_d    = 1'b0;
                        rr_ptr_d  = wrap_add(grant_q, 1);
                        state_d   = StArb;
                    end
                end
            end

            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArb;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            gap_cnt_q  <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            lock_to_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_start_q <= tx_start_d;
            ack_q      <= ack_d;
            lock_to_q  <= lock_to_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.cli_ack  = ack_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.lock_to  = lock_to_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queued client models, a UART transmitter model and a
// packet-level round-robin reference for the served byte order.
module tb_uart_tx_arb;
    localparam int unsigned N   = 4;
    localparam int unsigned GAP = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.N_CLIENTS(N)) bus ();

    uart_tx_arb #(
        .N_CLIENTS  (N),
        .GAP_TIMEOUT(GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Client models: each client is a FIFO of {last, data}; req is level while non-empty.
    logic [8:0] cmem [N][64];
    logic [5:0] c_wr [N] = '{default: '0};
    logic [5:0] c_rd [N] = '{default: '0};

    always_comb begin
        bus.cli_req  = '0;
        bus.cli_data = '0;
        bus.cli_last = '0;
        for (int i = 0; i < N; i++) begin
            bus.cli_req[i]         = (c_rd[i] != c_wr[i]);
            bus.cli_data[8*i +: 8] = cmem[i][c_rd[i]][7:0];
            bus.cli_last[i]        = cmem[i][c_rd[i]][8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.cli_ack[i]) c_rd[i] <= c_rd[i] + 6'd1;
        end
    end

    task automatic push(input int c, input logic last, input logic [7:0] d);
        cmem[c][c_wr[c]] = {last, d};
        c_wr[c] = c_wr[c] + 6'd1;
    endtask

    // Transmitter model: busy for frame cycles after tx_start, low combinationally on launch.
    logic [7:0]  tx_cnt;
    int unsigned frame_fix = 0;
    assign bus.tx_rdy = (tx_cnt == 8'd0) && !bus.tx_start;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_cnt <= 8'd0;
        else if (bus.tx_start)
            tx_cnt <= (frame_fix != 0) ? 8'(frame_fix) : 8'($urandom_range(1, 5));
        else if (tx_cnt != 8'd0) tx_cnt <= tx_cnt - 8'd1;
    end

    // Monitor: log every launch and count protocol violations.
    logic [1:0] obs_id  [512];
    logic [7:0] obs_dat [512];
    int   obs_n = 0;
    int   v_idle = 0, v_ack = 0, v_dbl = 0, v_lock = 0;
    logic prev_start = 1'b0, prev_lock = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_start) begin
                if (tx_cnt != 8'd0) v_idle <= v_idle + 1;
                if (prev_start) v_dbl <= v_dbl + 1;
                if (bus.cli_ack != (4'b0001 << bus.grant_id)) v_ack <= v_ack + 1;
                obs_id[obs_n]  <= bus.grant_id;
                obs_dat[obs_n] <= bus.tx_data;
                obs_n          <= obs_n + 1;
            end else if (bus.cli_ack != '0) begin
                v_ack <= v_ack + 1;
            end
            if (bus.lock_to && prev_lock) v_lock <= v_lock + 1;
        end
        prev_start <= bus.tx_start;
        prev_lock  <= bus.lock_to;
    end

    logic [9:0] exp_q [$];

    task automatic exp_push(input int c, input logic [7:0] d);
        exp_q.push_back({2'(c), d});
    endtask

    task automatic run_and_check(input string tag, input int base, input int budget);
        int cyc = 0;
        while ((obs_n - base) < exp_q.size() && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        while (bus.busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 32'(obs_n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_n - base; i++)
            check($sformatf("%s_byte%0d", tag, i), {22'd0, obs_id[base+i], obs_dat[base+i]},
                  {22'd0, exp_q[i]});
        exp_q.delete();
    endtask

    task automatic wait_start(input string tag, input int budget);
        int cyc = 0;
        @(negedge clk);
        while (!bus.tx_start && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_start_seen"}, 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_frame_end(input string tag, input int budget);
        int cyc = 0;
        @(negedge clk);
        while (!bus.tx_rdy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_frame_end"}, 32'(bus.tx_rdy), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < N; c++) c_wr[c] = c_rd[c];
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
        check({tag, "_ack"},      32'(bus.cli_ack),  32'd0);
        check({tag, "_grant"},    32'(bus.grant_id), 32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_lock_to"},  32'(bus.lock_to),  32'd0);
    endtask

    int          base, n, lt;
    int          npk [N];
    int          plen [N][4];
    logic [7:0]  pdat [N][4][4];
    int          taken [N];

    initial begin
        for (int c = 0; c < N; c++)
            for (int k = 0; k < 64; k++) cmem[c][k] = 9'h000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single byte from client 0.
        push(0, 1'b1, 8'hA5);
        wait_start("single", 50);
        check("single_data", 32'(bus.tx_data), 32'hA5);
        check("single_ack",  32'(bus.cli_ack), 32'h1);
        check("single_busy", 32'(bus.busy), 32'd1);
        wait_frame_end("single", 50);
        check("single_busy_hold", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("single_busy_fall", 32'(bus.busy), 32'd0);
        // rr_ptr now 1: client 1 beats client 0.
        base = obs_n;
        push(0, 1'b1, 8'hB0);
        push(1, 1'b1, 8'hB1);
        exp_push(1, 8'hB1);
        exp_push(0, 8'hB0);
        run_and_check("rr_after_single", base, 200);

        // Contention from reset.
        do_reset();
        base = obs_n;
        push(1, 1'b1, 8'h11);
        push(2, 1'b1, 8'h22);
        exp_push(1, 8'h11);
        exp_push(2, 8'h22);
        run_and_check("contention", base, 200);

        // Packet lock against a waiting client 3.
        do_reset();
        base = obs_n;
        push(0, 1'b0, 8'h01);
        push(0, 1'b0, 8'h02);
        push(0, 1'b1, 8'h03);
        push(3, 1'b1, 8'h33);
        exp_push(0, 8'h01);
        exp_push(0, 8'h02);
        exp_push(0, 8'h03);
        exp_push(3, 8'h33);
        run_and_check("lock", base, 300);

        // Fairness with everyone requesting.
        do_reset();
        base = obs_n;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) push(c, 1'b1, 8'(c * 16 + k));
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) exp_push(c, 8'(c * 16 + k));
        run_and_check("fair", base, 400);

        // Gap timeout: lock_to on the 17th negedge after the frame-end cycle.
        do_reset();
        frame_fix = 3;
        base = obs_n;
        push(2, 1'b0, 8'h2A);
        wait_start("gap", 50);
        wait_frame_end("gap", 50);
        n = 0;
        while (!bus.lock_to && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                push(1, 1'b1, 8'h1C);
                push(3, 1'b1, 8'h3C);
            end
            if (n == 16) check("gap_busy_locked", 32'(bus.busy), 32'd1);
        end
        check("gap_lock_to_time", 32'(n), 32'd17);
        check("gap_busy_released", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("gap_lock_to_pulse", 32'(bus.lock_to), 32'd0);
        exp_push(2, 8'h2A);
        exp_push(3, 8'h3C);
        exp_push(1, 8'h1C);
        run_and_check("gap", base, 200);

        // Request returns on the last counted gap cycle: no timeout.
        do_reset();
        base = obs_n;
        push(2, 1'b0, 8'h5A);
        wait_start("gapv", 50);
        wait_frame_end("gapv", 50);
        lt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.lock_to) lt++;
            if (i == 2) push(0, 1'b1, 8'h50);
            if (i == 16) push(2, 1'b1, 8'h5B);
        end
        check("gapv_no_lock_to", 32'(lt), 32'd0);
        exp_push(2, 8'h5A);
        exp_push(2, 8'h5B);
        exp_push(0, 8'h50);
        run_and_check("gapv", base, 200);

        // Asynchronous reset during a frame.
        do_reset();
        frame_fix = 8;
        push(2, 1'b1, 8'h77);
        wait_start("midrst", 50);
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        check("midrst_grant_before", 32'(bus.grant_id), 32'd2);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        push(1, 1'b1, 8'h71);
        push(3, 1'b1, 8'h73);
        base = obs_n;
        @(negedge clk);
        rst_n = 1'b1;
        exp_push(1, 8'h71);
        exp_push(3, 8'h73);
        run_and_check("midrst", base, 200);
        frame_fix = 0;

        // Random packets against the packet-level round-robin reference.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            base = obs_n;
            for (int c = 0; c < N; c++) begin
                npk[c]   = int'($urandom_range(0, 3));
                taken[c] = 0;
                for (int k = 0; k < npk[c]; k++) begin
                    plen[c][k] = int'($urandom_range(1, 4));
                    for (int b = 0; b < plen[c][k]; b++) begin
                        pdat[c][k][b] = 8'($urandom);
                        push(c, (b == plen[c][k] - 1), pdat[c][k][b]);
                    end
                end
            end
            begin
                int p, rem, found;
                p = 0;
                rem = 0;
                for (int c = 0; c < N; c++) rem += npk[c];
                while (rem > 0) begin
                    found = -1;
                    for (int o = 0; o < N; o++)
                        if (found < 0 && taken[(p + o) % N] < npk[(p + o) % N]) found = (p + o) % N;
                    for (int b = 0; b < plen[found][taken[found]]; b++)
                        exp_push(found, pdat[found][taken[found]][b]);
                    taken[found]++;
                    p = (found + 1) % N;
                    rem--;
                end
            end
            run_and_check($sformatf("rand%0d", it), base, 2000);
        end

        check("mon_start_when_idle", 32'(v_idle), 32'd0);
        check("mon_ack_onehot",      32'(v_ack),  32'd0);
        check("mon_start_single",    32'(v_dbl),  32'd0);
        check("mon_lock_to_single",  32'(v_lock), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
